// File: rtl/prng_selector_nlfsr_if.sv
// Bus between the NLFSR tap-search core and its search controller.
// The controller (master) drives run enable and the external feedback bit.
interface prng_selector_nlfsr_if #(
  parameter int NUM_OF_TAPS = 6,
  parameter int SIZE        = 16
);
  logic                     ena;
  logic                     feedback;
  logic [7:0]               prng_byte;
  logic                     prng_valid;
  logic [NUM_OF_TAPS*8-1:0] taps;
  logic                     selector_done;
  logic [SIZE-1:0]          state;
  logic                     found;
  logic                     failure;

  modport master (
    output ena, feedback,
    input  prng_byte, prng_valid, taps, selector_done, state, found, failure
  );

  modport slave (
    input  ena, feedback,
    output prng_byte, prng_valid, taps, selector_done, state, found, failure
  );
endinterface

// File: rtl/prng_selector_nlfsr.sv
// NLFSR tap-search core: xorshift32 byte source, distinct-tap selector and a
// shift register whose period is judged maximal (found) or not (failure).
module prng_selector_nlfsr #(
  parameter int          NUM_OF_TAPS = 6,
  parameter int          SIZE        = 16,
  parameter logic [31:0] SEED        = 32'd13413515
) (
  input logic                  clk,
  input logic                  res,
  prng_selector_nlfsr_if.slave bus
);

  localparam int              FILL_W  = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
  localparam logic [FILL_W-1:0] LAST  = FILL_W'(NUM_OF_TAPS - 1);
  localparam logic [SIZE-1:0] ONE     = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE:0]   PERIOD  = {1'b0, {SIZE{1'b1}}};
  localparam logic [SIZE:0]   CNT_ONE = {{SIZE{1'b0}}, 1'b1};

  // ---------------------------------------------------------------- PRNG
  logic [31:0] x_q;
  logic [31:0] x_cur;
  logic [31:0] x_s1;
  logic [31:0] x_s2;
  logic [31:0] x_nxt;
  logic [7:0]  prng_byte;
  logic        prng_valid;

  // A register at its power-up value of 0 stands for SEED; xorshift never
  // reaches 0 from a nonzero state, so 0 cannot occur once running.
  always_comb begin
    x_cur = (x_q == 32'd0) ? SEED : x_q;
    x_s1  = x_cur ^ (x_cur << 13);
    x_s2  = x_s1 ^ (x_s1 >> 17);
    x_nxt = x_s2 ^ (x_s2 << 5);
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; this register deliberately ignores res so retries differ.
  always_ff @(posedge clk) begin
    x_q <= x_nxt;
  end

  assign prng_byte  = x_cur[7:0];
  assign prng_valid = 1'b1;

  // ------------------------------------------------------------ selector
  logic [7:0]        slot_q [NUM_OF_TAPS];
  logic [FILL_W-1:0] fill_q;
  logic              done_q;
  logic [7:0]        cand;
  logic              dup;
  logic              accept;
  logic [NUM_OF_TAPS*8-1:0] taps_w;

  assign cand = 8'({1'b0, prng_byte} % 9'(SIZE));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    dup = 1'b0;
    // Unfilled slots hold 0 and a zero candidate is rejected anyway, so
    // comparing against all slots equals comparing against filled ones.
    for (int i = 0; i < NUM_OF_TAPS; i++) begin
      if (slot_q[i] == cand) dup = 1'b1;
    end
  end

  assign accept = bus.ena && prng_valid && !done_q && (cand != 8'd0) && !dup;

  // NOTE: the slot array is reset on purpose: unfilled slots must read 0
  // and the duplicate check relies on that.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < NUM_OF_TAPS; i++) slot_q[i] <= 8'd0;
      fill_q <= '0;
      done_q <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < NUM_OF_TAPS; i++) begin
        if (fill_q == FILL_W'(i)) slot_q[i] <= cand;
      end
      if (fill_q == LAST) done_q <= 1'b1;
      else                fill_q <= fill_q + FILL_W'(1);
    end
  end

  always_comb begin
    taps_w = '0;
    for (int i = 0; i < NUM_OF_TAPS; i++) taps_w[8*i +: 8] = slot_q[i];
  end

  // --------------------------------------------------------------- NLFSR
  logic [SIZE-1:0] state_q;
  logic [SIZE-1:0] state_nxt;
  logic [SIZE:0]   cnt_q;
  logic [SIZE:0]   cnt_nxt;
  logic            found_q;
  logic            failure_q;
  logic            step;
  logic            set_found;
  logic            set_failure;

  always_comb begin
    step        = bus.ena && done_q && !found_q && !failure_q;
    state_nxt   = {state_q[SIZE-2:0], bus.feedback};
    cnt_nxt     = cnt_q + CNT_ONE;
    set_found   = 1'b0;
    set_failure = 1'b0;
    // Verdict looks at the post-step values so it lands on the deciding edge.
    if (step) begin
      if (state_nxt == ONE && cnt_nxt == PERIOD)
        set_found = 1'b1;
      else if (state_nxt == ONE || state_nxt == '0 || cnt_nxt == PERIOD)
        set_failure = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= ONE;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      failure_q <= 1'b0;
    end else begin
      if (step) begin
        state_q <= state_nxt;
        cnt_q   <= cnt_nxt;
      end
      if (set_found)   found_q   <= 1'b1;
      if (set_failure) failure_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------- outputs
  assign bus.prng_byte     = prng_byte;
  assign bus.prng_valid    = prng_valid;
  assign bus.taps          = taps_w;
  assign bus.selector_done = done_q;
  assign bus.state         = state_q;
  assign bus.found         = found_q;
  assign bus.failure       = failure_q;

endmodule

// File: tb/tb_prng_selector_nlfsr.sv
// Bench for prng_selector_nlfsr: a 16-bit/6-tap instance exercises the selector,
// a 4-bit/2-tap instance exercises the NLFSR verdicts; both track one model.
module tb_prng_selector_nlfsr;

  localparam logic [31:0] SEED = 32'd13413515;

  typedef enum int {FB_MAX, FB_ROT, FB_ZERO} fb_mode_e;

  logic     clk;
  logic     res_v [2];
  logic     ena_v [2];
  fb_mode_e mode;

  int checks = 0;
  int errors = 0;

  prng_selector_nlfsr_if #(.NUM_OF_TAPS(6), .SIZE(16)) if16 ();
  prng_selector_nlfsr_if #(.NUM_OF_TAPS(2), .SIZE(4))  if4 ();

  prng_selector_nlfsr #(.NUM_OF_TAPS(6), .SIZE(16)) dut16 (
    .clk (clk),
    .res (res_v[0]),
    .bus (if16)
  );

  prng_selector_nlfsr #(.NUM_OF_TAPS(2), .SIZE(4)) dut4 (
    .clk (clk),
    .res (res_v[1]),
    .bus (if4)
  );

  assign if16.ena      = ena_v[0];
  assign if16.feedback = 1'b0;
  assign if4.ena       = ena_v[1];

  always_comb begin
    if4.feedback = 1'b0;
    case (mode)
      FB_MAX:  if4.feedback = if4.state[3] ^ if4.state[2];
      FB_ROT:  if4.feedback = if4.state[3];
      default: if4.feedback = 1'b0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ------------------------------------------------------ reference model
  int          sz [2] = '{16, 4};
  int          nt [2] = '{6, 2};
  logic [31:0] xm;
  int          slots [2][8];
  int          fill [2];
  int          mst [2];
  int          mcnt [2];
  bit          mfound [2];
  bit          mfail [2];
  int          cyc;
  int          first_step [2];
  int          verdict_cyc;
  int          seq4 [$];

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [63:0] exp_taps(input int k);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nt[k]; i++) v[8*i +: 8] = 8'(slots[k][i]);
    return v;
  endfunction

  function automatic int model_fb(input int k);
    if (k == 0) return 0;
    case (mode)
      FB_MAX:  return ((mst[1] >> 3) & 1) ^ ((mst[1] >> 2) & 1);
      FB_ROT:  return (mst[1] >> 3) & 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) slots[k][i] = 0;
    fill[k]   = 0;
    mst[k]    = 1;
    mcnt[k]   = 0;
    mfound[k] = 1'b0;
    mfail[k]  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("byte16",   64'(if16.prng_byte), 64'(xm[7:0]));
    check("byte4",    64'(if4.prng_byte),  64'(xm[7:0]));
    check("valid16",  64'(if16.prng_valid), 64'(1));
    check("taps16",   64'(if16.taps), exp_taps(0));
    check("taps4",    64'(if4.taps),  exp_taps(1));
    check("done16",   64'(if16.selector_done), 64'(fill[0] == nt[0]));
    check("done4",    64'(if4.selector_done),  64'(fill[1] == nt[1]));
    check("state16",  64'(if16.state), 64'(mst[0]));
    check("state4",   64'(if4.state),  64'(mst[1]));
    check("found16",  64'(if16.found),   64'(mfound[0]));
    check("found4",   64'(if4.found),    64'(mfound[1]));
    check("fail16",   64'(if16.failure), 64'(mfail[0]));
    check("fail4",    64'(if4.failure),  64'(mfail[1]));
    check("excl4",    64'(if4.found & if4.failure), 64'(0));
  endtask

  // Predict what the coming edge does from pre-edge inputs, clock, compare.
  task automatic tick();
    int  cand;
    bit  dup;
    int  nxt;
    int  n;
    int  full;
    bit  stepped [2];
    for (int k = 0; k < 2; k++) begin
      stepped[k] = 1'b0;
      full = (1 << sz[k]) - 1;
      if (!res_v[k] && ena_v[k]) begin
        if (fill[k] != nt[k]) begin
          cand = int'(xm[7:0]) % sz[k];
          dup  = 1'b0;
          for (int i = 0; i < fill[k]; i++) if (slots[k][i] == cand) dup = 1'b1;
          if (cand != 0 && !dup) begin
            slots[k][fill[k]] = cand;
            fill[k]++;
          end
        end else if (!mfound[k] && !mfail[k]) begin
          nxt = ((mst[k] << 1) | model_fb(k)) & full;
          n   = mcnt[k] + 1;
          mst[k]  = nxt;
          mcnt[k] = n;
          if (nxt == 1 && n == full)                  mfound[k] = 1'b1;
          else if (nxt == 1 || nxt == 0 || n == full) mfail[k]  = 1'b1;
          stepped[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    xm = xs(xm);
    cyc++;
    for (int k = 0; k < 2; k++) if (stepped[k] && mcnt[k] == 1) first_step[k] = cyc;
    if (stepped[1]) seq4.push_back(int'(if4.state));
    compare_all();
    if (verdict_cyc < 0 && (if4.found || if4.failure)) verdict_cyc = cyc;
  endtask

  task automatic res_pulse(input int k);
    res_v[k] = 1'b1;
    model_reset(k);
    if (k == 1) begin
      verdict_cyc = -1;
      seq4.delete();
    end
    #1;
    compare_all();
    tick();
    res_v[k] = 1'b0;
  endtask

  task automatic run_until_verdict4();
    int guard;
    guard = 0;
    while (verdict_cyc < 0 && guard < 300) begin
      tick();
      guard++;
    end
    if (verdict_cyc < 0) check("verdict4_timeout", 64'(if4.found | if4.failure), 64'(1));
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    int          acc16;
    int          guard;
    logic [47:0] prev16;
    logic [63:0] old_dut;
    logic [63:0] old_model;
    int          rot_exp  [4] = '{2, 4, 8, 1};
    int          zero_exp [4] = '{2, 4, 8, 0};

    mode        = FB_MAX;
    res_v[0]    = 1'b1;
    res_v[1]    = 1'b1;
    ena_v[0]    = 1'b0;
    ena_v[1]    = 1'b0;
    xm          = SEED;
    cyc         = 0;
    verdict_cyc = -1;
    first_step  = '{-1, -1};
    model_reset(0);
    model_reset(1);

    // Power-up, before any clock edge.
    #1;
    check("por_byte", 64'(if16.prng_byte), 64'(8'h8B));
    check("por_taps", 64'(if16.taps), 64'(0));
    check("por_state", 64'(if16.state), 64'(1));
    compare_all();
    #1;
    res_v[0] = 1'b0;
    res_v[1] = 1'b0;
    ena_v[1] = 1'b1;

    // Selector fill with a three-cycle ena gap on the 16-bit instance.
    acc16  = 0;
    guard  = 0;
    prev16 = '0;
    while (!if16.selector_done && guard < 200) begin
      ena_v[0] = !(guard >= 2 && guard < 5);
      tick();
      if (if16.taps !== prev16) begin
        acc16++;
        prev16 = if16.taps;
      end
      guard++;
    end
    check("done16_reached", 64'(if16.selector_done), 64'(1));
    check("accepts16", 64'(acc16), 64'(6));
    ena_v[0] = 1'b1;

    // Maximal-period feedback: found after exactly 15 steps.
    run_until_verdict4();
    check("max_found", 64'(if4.found), 64'(1));
    check("max_fail", 64'(if4.failure), 64'(0));
    check("max_steps", 64'(verdict_cyc - first_step[1] + 1), 64'(15));
    check("max_seq_len", 64'(seq4.size()), 64'(15));
    repeat (3) tick();
    check("max_frozen_state", 64'(if4.state), 64'(1));

    // Rotation: 2,4,8,1 then failure on step 4.
    mode = FB_ROT;
    res_pulse(1);
    check("rot_res_found", 64'(if4.found), 64'(0));
    check("rot_res_done", 64'(if4.selector_done), 64'(0));
    run_until_verdict4();
    check("rot_fail", 64'(if4.failure), 64'(1));
    check("rot_steps", 64'(verdict_cyc - first_step[1] + 1), 64'(4));
    for (int i = 0; i < 4 && i < seq4.size(); i++)
      check($sformatf("rot_state%0d", i), 64'(seq4[i]), 64'(rot_exp[i]));

    // Stuck at zero: 2,4,8,0 then failure on step 4.
    mode = FB_ZERO;
    res_pulse(1);
    run_until_verdict4();
    check("zero_fail", 64'(if4.failure), 64'(1));
    check("zero_steps", 64'(verdict_cyc - first_step[1] + 1), 64'(4));
    for (int i = 0; i < 4 && i < seq4.size(); i++)
      check($sformatf("zero_state%0d", i), 64'(seq4[i]), 64'(zero_exp[i]));

    // 16-bit instance fails with feedback 0; retry must draw fresh taps.
    guard = 0;
    while (!if16.failure && guard < 300) begin
      tick();
      guard++;
    end
    check("fail16_reached", 64'(if16.failure), 64'(1));
    old_dut   = 64'(if16.taps);
    old_model = exp_taps(0);
    res_pulse(0);
    check("retry_state16", 64'(if16.state), 64'(1));
    check("retry_fail16", 64'(if16.failure), 64'(0));
    guard = 0;
    while (!if16.selector_done && guard < 200) begin
      tick();
      guard++;
    end
    check("retry_done16", 64'(if16.selector_done), 64'(1));
    check("retry_differs", 64'(64'(if16.taps) !== old_dut), 64'(exp_taps(0) !== old_model));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
